// File: rtl/i2c_slave_target.sv
// i2c_slave_target: single-address I2C target with oversampled SCL/SDA.
// Optional majority glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_slave_target #(
   parameter int                    ADDR_WIDTH  = 7,
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2c_scl,
   input  logic                  i2c_sda,
   output logic                  sda_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_load,
   output logic                  busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
   } state_t;

   state_t                state, state_n;
   logic [1:0]            scl_sync, sda_sync;
   logic                  scl_f, sda_f, scl_q, sda_q;
   logic                  scl_rise, scl_fall, sda_rise, sda_fall;
   logic                  start, stop;
   logic [CW-1:0]         cnt, cnt_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n, rx_data_n;
   logic                  rw, rw_n, phase, phase_n, oe_n, rx_valid_n;

   // two-stage synchronizers, idle-high after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl};
         sda_sync <= {sda_sync[0], i2c_sda};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [2:0] scl_hist, sda_hist;

   // three-sample history feeding a majority vote
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_hist <= 3'b111;
         sda_hist <= 3'b111;
      end else begin
         scl_hist <= {scl_hist[1:0], scl_sync[1]};
         sda_hist <= {sda_hist[1:0], sda_sync[1]};
      end
   end

   assign scl_f = (scl_hist[0] & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[2]) |
                  (scl_hist[1] & scl_hist[2]);
   assign sda_f = (sda_hist[0] & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[2]) |
                  (sda_hist[1] & sda_hist[2]);
`else
   assign scl_f = scl_sync[1];
   assign sda_f = sda_sync[1];
`endif

   // previous-sample register for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise = scl_f & ~scl_q;
   assign scl_fall = ~scl_f & scl_q;
   assign sda_rise = sda_f & ~sda_q;
   assign sda_fall = ~sda_f & sda_q;
   assign start    = sda_fall & scl_f;
   assign stop     = sda_rise & scl_f;

   assign busy = (state == ADDR_ACK) || (state == WRITE) ||
                 (state == WRITE_ACK) || (state == READ) ||
                 (state == READ_ACK);

   // protocol state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         rw       <= 1'b0;
         phase    <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shreg    <= shreg_n;
         rw       <= rw_n;
         phase    <= phase_n;
         sda_oe   <= oe_n;
         rx_data  <= rx_data_n;
         rx_valid <= rx_valid_n;
      end
   end

   // next-state, bit handling and strobes
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      shreg_n    = shreg;
      rw_n       = rw;
      phase_n    = phase;
      oe_n       = sda_oe;
      rx_data_n  = rx_data;
      rx_valid_n = 1'b0;
      tx_load    = 1'b0;
      if (start) begin
         state_n = ADDR;
         cnt_n   = '0;
         oe_n    = 1'b0;
         phase_n = 1'b0;
      end else if (stop) begin
         state_n = IDLE;
         cnt_n   = '0;
         oe_n    = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            ADDR: if (scl_rise) begin
               shreg_n = {shreg[DATA_WIDTH-2:0], sda_f};
               cnt_n   = cnt + 1'b1;
               if (cnt == CW'(ADDR_WIDTH)) begin
                  cnt_n = '0;
                  if (shreg[ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                     state_n = ADDR_ACK;
                     rw_n    = sda_f;
                     phase_n = 1'b0;
                  end else begin
                     state_n = IGNORE;
                  end
               end
            end
            ADDR_ACK, WRITE_ACK: if (scl_fall) begin
               if (!phase) begin
                  oe_n    = 1'b1;
                  phase_n = 1'b1;
               end else begin
                  oe_n    = 1'b0;
                  phase_n = 1'b0;
                  cnt_n   = '0;
                  state_n = WRITE;
                  if (state == ADDR_ACK && rw) begin
                     tx_load = 1'b1;
                     shreg_n = {tx_data[DATA_WIDTH-2:0], 1'b0};
                     oe_n    = ~tx_data[DATA_WIDTH-1];
                     cnt_n   = CW'(1);
                     state_n = READ;
                  end
               end
            end
            WRITE: if (scl_rise) begin
               shreg_n = {shreg[DATA_WIDTH-2:0], sda_f};
               cnt_n   = cnt + 1'b1;
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  rx_data_n  = {shreg[DATA_WIDTH-2:0], sda_f};
                  rx_valid_n = 1'b1;
                  cnt_n      = '0;
                  phase_n    = 1'b0;
                  state_n    = WRITE_ACK;
               end
            end
            READ: if (scl_fall) begin
               if (cnt == CW'(DATA_WIDTH)) begin
                  oe_n    = 1'b0;
                  phase_n = 1'b0;
                  state_n = READ_ACK;
               end else begin
                  oe_n    = ~shreg[DATA_WIDTH-1];
                  shreg_n = {shreg[DATA_WIDTH-2:0], 1'b0};
                  cnt_n   = cnt + 1'b1;
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  if (sda_f) state_n = IGNORE;
                  else       phase_n = 1'b1;
               end else if (scl_fall && phase) begin
                  tx_load = 1'b1;
                  shreg_n = {tx_data[DATA_WIDTH-2:0], 1'b0};
                  oe_n    = ~tx_data[DATA_WIDTH-1];
                  cnt_n   = CW'(1);
                  phase_n = 1'b0;
                  state_n = READ;
               end
            end
            IGNORE: oe_n = 1'b0;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: directed bus transactions against i2c_slave_target.
// Glitch case runs only when I2C_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_target;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       i2c_scl, i2c_sda, sda_oe, rx_valid, tx_load, busy;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;

   int n_chk = 0;
   int n_fail = 0;
   int rxv_cyc = 0;
   int txl_cyc = 0;
   int oe_cyc = 0;

   assign i2c_scl = m_scl;
   assign i2c_sda = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_target dut (
      .clk      (clk),
      .reset    (reset),
      .i2c_scl  (i2c_scl),
      .i2c_sda  (i2c_sda),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .busy     (busy)
   );

   // cumulative strobe and drive counters
   always @(posedge clk) begin
      if (rx_valid) rxv_cyc++;
      if (tx_load)  txl_cyc++;
      if (sda_oe)   oe_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_io(input logic b, output logic r);
      m_sda = b;
      clks(Q);
      m_scl = 1'b1;
      clks(Q / 2);
      r = i2c_sda;
      clks(Q / 2);
      m_scl = 1'b0;
   endtask

   task automatic start_c;
      m_sda = 1'b1;
      clks(Q);
      m_scl = 1'b1;
      clks(Q);
      m_sda = 1'b0;
      clks(Q);
      m_scl = 1'b0;
   endtask

   task automatic stop_c;
      m_sda = 1'b0;
      clks(Q);
      m_scl = 1'b1;
      clks(Q);
      m_sda = 1'b1;
      clks(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(d[i], r);
      bit_io(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, r);
         d[i] = r;
      end
      bit_io(nack, r);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] d;
      int         rx0, tx0, oe0;
      logic [7:0] a0;

      a0 = 8'hA0;
      clks(3);
      check("rst_oe", sda_oe, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_load", tx_load, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      clks(5);

      // write 0x50/W, 0xA5, STOP
      rx0 = rxv_cyc;
      start_c;
      wr_byte(8'hA0, ack);
      check("w_addr_ack", ack, 1);
      check("w_busy", busy, 1);
      wr_byte(8'hA5, ack);
      check("w_data_ack", ack, 1);
      stop_c;
      clks(5);
      check("w_rx_data", rx_data, 8'hA5);
      check("w_rx_valid_cyc", rxv_cyc - rx0, 1);
      check("w_busy_end", busy, 0);

      // wrong address
      rx0 = rxv_cyc;
      oe0 = oe_cyc;
      start_c;
      wr_byte(8'hA2, ack);
      check("na_ack", ack, 0);
      check("na_busy", busy, 0);
      wr_byte(8'hFF, ack);
      check("na_data_ack", ack, 0);
      stop_c;
      clks(5);
      check("na_oe_cyc", oe_cyc - oe0, 0);
      check("na_rx_valid", rxv_cyc - rx0, 0);

      // read two bytes, ACK then NACK
      tx0 = txl_cyc;
      tx_data = 8'h3C;
      start_c;
      wr_byte(8'hA1, ack);
      check("r_addr_ack", ack, 1);
      rd_byte(1'b0, d);
      tx_data = 8'hC3;
      check("r_byte0", d, 8'h3C);
      rd_byte(1'b1, d);
      check("r_byte1", d, 8'hC3);
      clks(6);
      check("r_tx_load_cyc", txl_cyc - tx0, 2);
      check("r_ignore_busy", busy, 0);
      check("r_ignore_oe", sda_oe, 0);
      stop_c;
      clks(5);
      check("r_idle_busy", busy, 0);

      // write 0x12, repeated START, read
      rx0 = rxv_cyc;
      tx0 = txl_cyc;
      tx_data = 8'h81;
      start_c;
      wr_byte(8'hA0, ack);
      wr_byte(8'h12, ack);
      check("rs_w_ack", ack, 1);
      start_c;
      wr_byte(8'hA1, ack);
      check("rs_r_ack", ack, 1);
      clks(6);
      check("rs_tx_load", txl_cyc - tx0, 1);
      rd_byte(1'b1, d);
      check("rs_rd", d, 8'h81);
      stop_c;
      clks(5);
      check("rs_rx_valid", rxv_cyc - rx0, 1);
      check("rs_rx_data", rx_data, 8'h12);

      // STOP after 4 data bits
      rx0 = rxv_cyc;
      start_c;
      wr_byte(8'hA0, ack);
      for (int i = 0; i < 4; i++) bit_io(i[0], r);
      stop_c;
      clks(5);
      check("ps_rx_valid", rxv_cyc - rx0, 0);
      check("ps_rx_data", rx_data, 8'h12);
      check("ps_busy", busy, 0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // 1-clk SCL low glitch during a data bit
      d = 8'h5A;
      start_c;
      wr_byte(8'hA0, ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = d[i];
         clks(Q);
         m_scl = 1'b1;
         clks(4);
         if (i == 3) begin
            m_scl = 1'b0;
            clks(1);
            m_scl = 1'b1;
         end
         clks(4);
         m_scl = 1'b0;
      end
      bit_io(1'b1, r);
      stop_c;
      clks(5);
      check("gl_rx_data", rx_data, 8'h5A);
`endif

      // reset during address ACK
      start_c;
      for (int i = 7; i >= 0; i--) bit_io(a0[i], r);
      m_sda = 1'b1;
      clks(6);
      check("ra_oe_on", sda_oe, 1);
      reset = 1'b0;
      #1;
      check("ra_oe_off", sda_oe, 0);
      check("ra_busy", busy, 0);
      check("ra_rx_data", rx_data, 0);
      clks(2);
      reset = 1'b1;
      clks(Q);
      m_scl = 1'b1;
      clks(Q);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
